// File: rtl/tinyalu_pkg.sv
// Opcode encoding shared by the TinyALU and its command initiator.
package tinyalu_pkg;

  typedef enum logic [3:0] {
    op_nop  = 4'h0,
    op_add  = 4'h1,
    op_and  = 4'h2,
    op_xor  = 4'h3,
    op_mul  = 4'h4,
    op_sp0  = 4'h5,
    op_sp1  = 4'h6,
    op_sp2  = 4'h7,
    op_shl  = 4'h8,
    op_shr  = 4'h9,
    op_res0 = 4'hA,
    op_res1 = 4'hB,
    op_res2 = 4'hC,
    op_res3 = 4'hD,
    op_res4 = 4'hE,
    op_nop1 = 4'hF
  } alu_opcode_t;

endpackage

// File: rtl/alu_cmd_initiator.sv
// Requester side of the ALU start/done handshake: buffers commands in a FIFO,
// issues them one at a time to the ALU and returns result/error/latency.
//
// Handshakes: cmd_* transfers on the rising edge where cmd_valid && cmd_ready;
// rsp_* transfers on the rising edge where rsp_valid && rsp_ready. A valid
// source holds its payload stable until the transfer edge.
module alu_cmd_initiator
  import tinyalu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  alu_opcode_t cmd_op,
  output logic [7:0]  alu_A,
  output logic [7:0]  alu_B,
  output alu_opcode_t alu_op,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic        alu_error,
  input  logic [15:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output alu_opcode_t rsp_op,
  output logic        rsp_error,
  output logic        rsp_timeout,
  output logic [7:0]  rsp_cycles,
  output logic        busy
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [7:0]  TO_LAST  = 8'(TIMEOUT_CYC - 1);
  localparam logic [7:0]  TO_CYC   = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state;

  // Command FIFO storage and bookkeeping
  logic [7:0]    fifo_a  [DEPTH];
  logic [7:0]    fifo_b  [DEPTH];
  alu_opcode_t   fifo_op [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [7:0]    head_a;
  logic [7:0]    head_b;
  alu_opcode_t   head_op;
  logic          head_is_nop;

  // BUSY-cycle counter used for latency and timeout
  logic [7:0]    cnt;

  assign fifo_empty  = (count == '0);
  assign cmd_ready   = (count != FULL_CNT);
  assign push        = cmd_valid && cmd_ready;
  assign pop         = (state == ST_IDLE) && !fifo_empty;
  assign head_a      = fifo_a[rd_ptr];
  assign head_b      = fifo_b[rd_ptr];
  assign head_op     = fifo_op[rd_ptr];
  // The ALU never answers these, so they are completed locally.
  assign head_is_nop = (head_op == op_nop) || (head_op == op_nop1);
  assign busy        = (state != ST_IDLE) || !fifo_empty;

  // FIFO payload write; storage needs no reset since count guards reads
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_a[wr_ptr]  <= cmd_a;
      fifo_b[wr_ptr]  <= cmd_b;
      fifo_op[wr_ptr] <= cmd_op;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Issue FSM with registered ALU-side and response-side outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      alu_start   <= 1'b0;
      alu_A       <= '0;
      alu_B       <= '0;
      alu_op      <= op_nop;
      cnt         <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_op      <= op_nop;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_cycles  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_A  <= head_a;
            alu_B  <= head_b;
            alu_op <= head_op;
            if (head_is_nop) begin
              rsp_result  <= '0;
              rsp_op      <= head_op;
              rsp_error   <= 1'b0;
              rsp_timeout <= 1'b0;
              rsp_cycles  <= '0;
              rsp_valid   <= 1'b1;
              state       <= ST_RESP;
            end else begin
              alu_start <= 1'b1;
              cnt       <= '0;
              state     <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          // done takes priority over an expiring timeout on the same edge
          if (alu_done) begin
            rsp_result  <= alu_result;
            rsp_op      <= alu_op;
            rsp_error   <= alu_error;
            rsp_timeout <= 1'b0;
            rsp_cycles  <= cnt;
            rsp_valid   <= 1'b1;
            alu_start   <= 1'b0;
            state       <= ST_RESP;
          end else if (cnt == TO_LAST) begin
            rsp_result  <= '0;
            rsp_op      <= alu_op;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_cycles  <= TO_CYC;
            rsp_valid   <= 1'b1;
            alu_start   <= 1'b0;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RESP: begin
          // Passing through IDLE keeps alu_start low for two or more cycles.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_cmd_initiator.sv
// Bench for alu_cmd_initiator: behavioural TinyALU model, directed steps,
// response scoreboard and a final report.
module tb_alu_cmd_initiator;
  import tinyalu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  alu_opcode_t cmd_op;
  logic [7:0]  alu_A;
  logic [7:0]  alu_B;
  alu_opcode_t alu_op;
  logic        alu_start;
  logic        alu_done;
  logic        alu_error;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  alu_opcode_t rsp_op;
  logic        rsp_error;
  logic        rsp_timeout;
  logic [7:0]  rsp_cycles;
  logic        busy;

  int checks = 0;
  int errors = 0;

  // {result[15:0], op[3:0], error, timeout, cycles[7:0]}
  localparam int W = 30;
  logic [W-1:0] exp_q[$];

  bit hang      = 1'b0;
  bit rnd_ready = 1'b0;

  alu_cmd_initiator #(.DEPTH(4), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_start(alu_start), .alu_done(alu_done),
    .alu_error(alu_error), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_op(rsp_op),
    .rsp_error(rsp_error), .rsp_timeout(rsp_timeout),
    .rsp_cycles(rsp_cycles), .busy(busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference ALU behaviour ----------------
  function automatic bit is_nop(input alu_opcode_t op);
    return (op == op_nop) || (op == op_nop1);
  endfunction

  function automatic bit is_res(input alu_opcode_t op);
    return (op inside {op_res0, op_res1, op_res2, op_res3, op_res4});
  endfunction

  function automatic int lat(input alu_opcode_t op);
    case (op)
      op_add, op_and, op_xor, op_shl, op_shr: return 1;
      op_mul, op_sp1, op_sp2:                 return 3;
      op_sp0:                                 return 4;
      default:                                return 0;
    endcase
  endfunction

  function automatic logic [15:0] model_res(input alu_opcode_t op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] wa;
    logic [15:0] wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (op)
      op_add:          return wa + wb;
      op_and:          return wa & wb;
      op_xor:          return wa ^ wb;
      op_mul:          return wa * wb;
      op_sp0:          return wa + (wb << 1);
      op_sp1:          return (wa * wb) + wa;
      op_sp2:          return (wa * wb) ^ 16'h5555;
      op_shl:          return wa << 1;
      op_shr:          return wa >> 1;
      op_nop, op_nop1: return 16'h0000;
      default:         return 16'h0BAD;
    endcase
  endfunction

  // ALU model: done after lat(op) edges with start high, never for nops
  logic [7:0] k;
  always @(posedge clk) begin
    if (!alu_start) k <= 8'd0;
    else            k <= k + 8'd1;
  end

  always_comb begin
    alu_done   = alu_start && !hang && !is_nop(alu_op) && (int'(k) == lat(alu_op));
    alu_error  = is_res(alu_op);
    alu_result = model_res(alu_op, alu_A, alu_B);
  end

  // ---------------- check helper ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- ALU-side monitors ----------------
  int          start_len = 0;
  int          stab_err  = 0;
  logic        prev_start;
  logic [19:0] prev_ops;
  always @(negedge clk) begin
    if (alu_start) start_len <= start_len + 1;
    if (alu_start && prev_start && ({alu_A, alu_B, alu_op} != prev_ops))
      stab_err <= stab_err + 1;
    prev_start <= alu_start;
    prev_ops   <= {alu_A, alu_B, alu_op};
  end

  // ---------------- response scoreboard ----------------
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [W-1:0] w;
        w = exp_q.pop_front();
        chk("rsp_result", 32'(rsp_result), 32'(w[29:14]));
        chk("rsp_status", 32'({rsp_op, rsp_error, rsp_timeout, rsp_cycles}), 32'(w[13:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input alu_opcode_t op,
                      input bit expect_rsp, input logic [15:0] e_res, input bit e_err,
                      input bit e_to, input logic [7:0] e_cyc);
    bit ok;
    ok = 1'b0;
    if (expect_rsp) exp_q.push_back({e_res, op, e_err, e_to, e_cyc});
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    for (int n = 0; n < 400; n++) begin
      if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = cmd_ready;
      tick();
      if (ok) break;
    end
    cmd_valid = 1'b0;
    if (!ok) chk("cmd_accept_timeout", 32'(ok), 32'd1);
  endtask

  task automatic send_model(input logic [7:0] a, input logic [7:0] b, input alu_opcode_t op);
    logic [15:0] r;
    logic [7:0]  c;
    r = is_nop(op) ? 16'h0000 : model_res(op, a, b);
    c = is_nop(op) ? 8'd0 : 8'(lat(op));
    send(a, b, op, 1'b1, r, is_res(op), 1'b0, c);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (rnd_ready) rsp_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      ok = (exp_q.size() == 0) && !busy && !rsp_valid;
      tick();
      if (ok) break;
    end
    if (!ok) chk("drain_timeout", 32'(ok), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int s0;
    int t0;
    bit seen;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_a     = 8'h00;
    cmd_b     = 8'h00;
    cmd_op    = op_nop;
    rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_alu_start", 32'(alu_start), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_alu_op",    32'(alu_op), 32'(op_nop));
    chk("rst_alu_ab",    32'({alu_A, alu_B}), 32'd0);
    chk("rst_rsp_flds",  32'({rsp_result, rsp_error, rsp_timeout, rsp_cycles}), 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // add: start high exactly 2 cycles
    s0 = start_len;
    send(8'h12, 8'h34, op_add, 1'b1, 16'h0046, 1'b0, 1'b0, 8'd1);
    drain();
    chk("add_start_len", 32'(start_len - s0), 32'd2);

    // mul and sp0 with operand stability through BUSY
    s0 = stab_err;
    send(8'hFF, 8'hFF, op_mul, 1'b1, 16'hFE01, 1'b0, 1'b0, 8'd3);
    send(8'h05, 8'h10, op_sp0, 1'b1, 16'h0025, 1'b0, 1'b0, 8'd4);
    drain();
    chk("busy_operand_stable", 32'(stab_err - s0), 32'd0);

    // reserved opcode, then nop which never pulses start
    send(8'h01, 8'h02, op_res1, 1'b1, 16'h0BAD, 1'b1, 1'b0, 8'd0);
    drain();
    s0 = start_len;
    send(8'h33, 8'h44, op_nop, 1'b1, 16'h0000, 1'b0, 1'b0, 8'd0);
    send(8'h55, 8'h66, op_nop1, 1'b1, 16'h0000, 1'b0, 1'b0, 8'd0);
    drain();
    chk("nop_start_len", 32'(start_len - s0), 32'd0);

    // Five back-to-back pushes with the response side stalled
    rsp_ready = 1'b0;
    send(8'h01, 8'h02, op_add, 1'b1, 16'h0003, 1'b0, 1'b0, 8'd1);
    send(8'hF0, 8'h0F, op_xor, 1'b1, 16'h00FF, 1'b0, 1'b0, 8'd1);
    send(8'h03, 8'h04, op_mul, 1'b1, 16'h000C, 1'b0, 1'b0, 8'd3);
    send(8'h77, 8'h88, op_nop, 1'b1, 16'h0000, 1'b0, 1'b0, 8'd0);
    send(8'hAA, 8'h0F, op_and, 1'b1, 16'h000A, 1'b0, 1'b0, 8'd1);
    @(negedge clk);
    chk("full_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_rsp_held", 32'({rsp_valid, rsp_result, rsp_cycles}), 32'({1'b1, 16'h0003, 8'd1}));
    end
    tick();
    rsp_ready = 1'b1;
    drain();

    // Timeout: ALU never answers
    hang      = 1'b1;
    rsp_ready = 1'b0;
    s0        = start_len;
    send(8'h10, 8'h20, op_add, 1'b1, 16'h0000, 1'b0, 1'b1, 8'd16);
    seen = 1'b0;
    for (t0 = 0; t0 < 100; t0++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    chk("to_rsp_seen",   32'(seen), 32'd1);
    chk("to_alu_start",  32'(alu_start), 32'd0);
    chk("to_rsp_flag",   32'(rsp_timeout), 32'd1);
    chk("to_start_len",  32'(start_len - s0), 32'd16);
    tick();
    hang      = 1'b0;
    rsp_ready = 1'b1;
    drain();

    // Reset in the middle of a BUSY sp0 with another command queued
    send(8'h05, 8'h10, op_sp0, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);
    send(8'h01, 8'h01, op_add, 1'b0, 16'h0000, 1'b0, 1'b0, 8'd0);
    chk("mid_busy_start", 32'(alu_start), 32'd1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_start",  32'(alu_start), 32'd0);
    chk("mid_rst_valid",  32'(rsp_valid), 32'd0);
    chk("mid_rst_empty",  32'(busy), 32'd0);
    chk("mid_rst_ready",  32'(cmd_ready), 32'd1);
    tick();
    reset_n = 1'b1;
    tick();
    send(8'h07, 8'h03, op_sp1, 1'b1, 16'h001C, 1'b0, 1'b0, 8'd3);
    drain();

    // Random commands with a randomly stalling response side
    rnd_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      send_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 alu_opcode_t'(4'($urandom_range(0, 15))));
    end
    drain();
    rnd_ready = 1'b0;
    rsp_ready = 1'b1;

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
